uart_tx_unit: RTL and testbench
===============================

# uart_tx_unit

Memory-mapped UART transmitter on the processor's peripheral bus (addresses ≥ 0x40000000). The MEM stage of the pipeline drives it with its peripheral-side read/write strobes, address and store data. The block buffers up to four bytes, serialises them as 8N1 frames on `uart_tx`, and raises a level interrupt on frame completion. Its read data is OR-merged with the other bus slaves, so it drives zero when not selected.

## Interface
Parameters:
- `BAUD_DIV`, default 5208: clock cycles per serial bit (50 MHz / 9600). Legal range 2..65535.
- `BASE_ADDR`, default 32'h40000018: address of TXDATA. UARTCON is at `BASE_ADDR`+8.

Ports:
- `clk`, input, 1: the single clock. Bus and serial logic both use it.
- `reset`, input, 1: asynchronous, active-low reset.
- `rd`, input, 1: peripheral read strobe from MEM stage.
- `wr`, input, 1: peripheral write strobe from MEM stage.
- `addr`, input, 32: byte address from MEM stage.
- `wdata`, input, 32: store data.
- `rdata`, output, 32: read data. Combinational; zero unless `rd` and the address matches.
- `uart_tx`, output, 1: serial line, idle high.
- `irq`, output, 1: level interrupt request to the pipeline interrupt logic.

## Operation
Register map:
- TXDATA (`BASE_ADDR`):
  - Write pushes `wdata[7:0]` into the FIFO.
  - Read returns 0.
- UARTCON (`BASE_ADDR`+8), read value is {26'b0, ovf, irq_en, done, empty, full, busy}:
  - `busy`: FSM is not in IDLE.
  - `full`: FIFO count = 4.
  - `empty`: FIFO count = 0.
  - `done`: sticky; set at the end of every frame.
  - `irq_en`: interrupt enable.
  - `ovf`: sticky; set when a push is dropped.
- UARTCON write:
  - `wdata[4]` loads `irq_en`.
  - `wdata[3]`=1 clears `done`.
  - `wdata[5]`=1 clears `ovf`.
  - All other bits are ignored.
- Writes whose address matches neither register are ignored.

FIFO:
- 4 entries × 8 bits, 2-bit read/write pointers plus a 3-bit count.
- Pointers wrap from 3 to 0.
- Push while full: byte dropped, `ovf` set, count unchanged.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds even when the FIFO is full, in which case `ovf` is not set.

FSM states and transitions:
- IDLE: `uart_tx`=1.
  - If FIFO not empty: pop into the 8-bit shift register, clear the bit counter, go to START.
- START: `uart_tx`=0 for `BAUD_DIV` cycles, then go to DATA.
- DATA: `uart_tx`=shift[0], LSB first.
  - Every `BAUD_DIV` cycles the shift register shifts right and the bit counter increments.
  - After 8 bits, go to STOP.
- STOP: `uart_tx`=1 for `BAUD_DIV` cycles. At the final cycle:
  - Set `done`.
  - If FIFO not empty: pop and go straight to START (no idle gap).
  - Otherwise go to IDLE.

Baud counter:
- 16-bit, counts 0..`BAUD_DIV`-1.
- Cleared on every state entry.
- Held at 0 in IDLE.

Interrupt:
- `irq` = `done` & `irq_en`, registered-free combinational AND of two flops.
- A `done` set and a `done` clear in the same cycle: set wins.

`uart_tx` comes directly from a flop (no combinational glitch on the line).

## Timing
- Reset values:
  - `uart_tx`=1, `irq`=0, `rdata`=0 (while `rd`=0).
  - FIFO empty, pointers 0, FSM IDLE.
  - `done`=`ovf`=`irq_en`=0.
- Reset asserted mid-frame: `uart_tx` returns high immediately and FIFO contents are discarded.
- Push to line latency:
  - Write sampled at posedge k. Count=1 after k.
  - With FSM idle, pop at posedge k+1; `uart_tx` falls after k+1.
- Frame length: exactly 10×`BAUD_DIV` cycles.
  - Start bit: cycles 0..`BAUD_DIV`-1.
  - Data bit i: cycles (i+1)·`BAUD_DIV`..(i+2)·`BAUD_DIV`-1.
- `done` is set at the posedge ending the stop bit, 10×`BAUD_DIV` cycles after the start bit began. `irq` follows in the same cycle.
- Back-to-back frames: the next start bit begins on the cycle after the previous stop bit ends.
- Status reads reflect flop state before the current posedge. A read and a write in the same cycle return pre-write values.

## Test plan
All scenarios use `BAUD_DIV`=4.
- Reset: hold `reset`=0 → `uart_tx`=1, `irq`=0, UARTCON read = 32'h00000004. Release reset → unchanged until the first write.
- Single byte: write 8'hA5 to TXDATA → `uart_tx` low one cycle after the write edge. Line then shows bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4. `done`=1 exactly 40 cycles after the start bit; `irq` stays 0 (`irq_en`=0).
- Interrupt: write UARTCON=32'h10, then TXDATA=8'h3C → `irq`=1 at frame end. Write UARTCON=32'h18 → `irq`=0 next cycle, `irq_en` stays 1.
- Burst/back-to-back: write 5 bytes 8'h01..8'h05 on consecutive cycles. Byte 1 pops immediately, so bytes 2–5 fit without overflow and `ovf`=0. Result: five contiguous 40-cycle frames with no idle gap, then `busy`=0 and `empty`=1.
- Overflow: with FSM mid-frame and FIFO full, write 8'hFF → `ovf`=1, byte absent from the line. Write UARTCON with bit5=1 → `ovf`=0.
- Reset mid-frame: assert `reset` during data bit 3 → `uart_tx`=1 same cycle. After release, UARTCON reads 32'h00000004 and no further frame is sent.

Source files
------------

// File: rtl/uart_tx_unit.sv
// uart_tx_unit
//   Memory-mapped 8N1 UART transmitter for the peripheral bus. Bytes written
//   to TXDATA are queued in a 4-entry FIFO and serialised LSB first on
//   uart_tx. A sticky 'done' flag is set at the end of each frame and, when
//   enabled, drives a level interrupt.
//
// Ports
//   clk     : single clock for bus and serial logic
//   reset   : asynchronous, active-low reset
//   rd, wr  : peripheral read / write strobes from the MEM stage
//   addr    : byte address (TXDATA = BASE_ADDR, UARTCON = BASE_ADDR + 8)
//   wdata   : store data
//   rdata   : combinational read data, zero unless a UARTCON read is selected
//   uart_tx : serial line, idle high, driven straight from a flop
//   irq     : done & irq_en
module uart_tx_unit #(
    parameter int unsigned BAUD_DIV  = 5208,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [31:0] CON_ADDR  = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wptr;
    logic [1:0]  rptr;
    logic [2:0]  count;

    logic        done;
    logic        ovf;
    logic        irq_en;

    logic        sel_tx;
    logic        sel_con;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        con_wr;
    logic        baud_end;
    logic        frame_end;
    logic        fifo_empty;
    logic        fifo_full;
    logic        busy;
    logic        unused_wdata;

    assign sel_tx     = (addr == BASE_ADDR);
    assign sel_con    = (addr == CON_ADDR);
    assign push       = wr && sel_tx;
    assign con_wr     = wr && sel_con;
    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'd4);
    assign busy       = (state != IDLE);
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign frame_end  = (state == STOP) && baud_end;

    // The FSM takes a byte either from IDLE or on the last stop-bit cycle,
    // which lets back-to-back frames run with no idle gap.
    assign pop        = !fifo_empty && ((state == IDLE) || frame_end);

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    assign irq        = done && irq_en;

    assign unused_wdata = ^{wdata[31:8]};

    always_comb begin
        rdata = 32'd0;
        if (rd && sel_con) begin
            rdata = {26'd0, ovf, irq_en, done, fifo_empty, fifo_full, busy};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= 2'd0;
            rptr  <= 2'd0;
            count <= 3'd0;
        end else begin
            if (push_ok) wptr <= wptr + 2'd1;
            if (pop)     rptr <= rptr + 2'd1;
            count <= count + 3'(push_ok) - 3'(pop);
        end
    end

    // FIFO storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr] <= wdata[7:0];
    end

    // Status flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (frame_end)                 done <= 1'b1;
            else if (con_wr && wdata[3])   done <= 1'b0;

            if (push && fifo_full && !pop) ovf <= 1'b1;
            else if (con_wr && wdata[5])   ovf <= 1'b0;

            if (con_wr) irq_en <= wdata[4];
        end
    end

    // Shift register: loaded on pop, shifted right at every data-bit boundary
    always_ff @(posedge clk) begin
        if (pop)                              shift <= fifo_mem[rptr];
        else if ((state == DATA) && baud_end) shift <= {1'b0, shift[7:1]};
    end

    // Serial FSM; uart_tx is registered and set with each transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    uart_tx  <= 1'b1;
                    if (pop) begin
                        state   <= START;
                        bit_cnt <= 3'd0;
                        uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= 16'd0;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            // shift[1] becomes shift[0] on this same edge
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        if (pop) begin
                            state   <= START;
                            bit_cnt <= 3'd0;
                            uart_tx <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                    uart_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Testbench for uart_tx_unit with BAUD_DIV = 4. Expected bytes and register
// reads are queued when the stimulus is issued; a serial receiver and a read
// monitor pop and compare them as the DUT produces frames and read data.
module tb_uart_tx_unit;

    localparam int          BD   = 4;
    localparam logic [31:0] TXA  = 32'h40000018;
    localparam logic [31:0] CONA = 32'h40000020;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irq;

    always #5 clk = ~clk;

    uart_tx_unit #(.BAUD_DIV(BD), .BASE_ADDR(TXA)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];
    logic [31:0] rd_q[$];
    int         start_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read monitor: every read cycle consumes one queued expectation
    always @(negedge clk) begin
        if (rd) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata: unexpected read, got %h expected none", rdata);
            end else begin
                chk("rdata", rdata, rd_q.pop_front());
            end
        end
    end

    // Serial receiver: samples mid-bit, 4 cycles per bit
    int         cyc = 0;
    bit         rx_on = 1'b0;
    int         rx_pos = 0;
    logic [7:0] rx_byte = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_pos = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_pos++;
            if (rx_pos == 2) begin
                chk("start_bit", {31'd0, uart_tx}, 32'd0);
            end else if ((rx_pos % 4 == 2) && (rx_pos < 38)) begin
                rx_byte[rx_pos/4 - 1] = uart_tx;
            end else if (rx_pos == 38) begin
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_byte: unexpected frame got %h expected none", rx_byte);
                end else begin
                    chk("frame_byte", {24'd0, rx_byte}, {24'd0, tx_q.pop_front()});
                end
            end
            if (rx_pos == 39) rx_on = 1'b0;
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
        addr = a;
        rd   = 1'b1;
        rd_q.push_back(e);
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rdata_no_rd", rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_read(CONA, 32'h4);
        reset = 1'b1;
        cycles(3);
        bus_read(CONA, 32'h4);
        chk("post_rst_uart_tx", {31'd0, uart_tx}, 32'd1);

        // Single byte, no interrupt
        tx_q.push_back(8'hA5);
        bus_write(TXA, 32'hA5);
        @(negedge clk);
        chk("line_before_pop", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        chk("line_after_pop", {31'd0, uart_tx}, 32'd0);
        repeat (39) @(posedge clk);
        #1;
        bus_read(CONA, 32'h05);
        bus_read(CONA, 32'h0C);
        chk("single_irq", {31'd0, irq}, 32'd0);

        // Interrupt
        bus_write(CONA, 32'h08);
        bus_write(CONA, 32'h10);
        chk("irq_armed_low", {31'd0, irq}, 32'd0);
        tx_q.push_back(8'h3C);
        bus_write(TXA, 32'h3C);
        repeat (40) @(posedge clk);
        #1;
        chk("irq_before_end", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        chk("irq_at_end", {31'd0, irq}, 32'd1);
        bus_write(CONA, 32'h18);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(CONA, 32'h14);

        // Unmapped accesses, then a five-byte burst
        bus_write(CONA, 32'h08);
        bus_write(32'h40000000, 32'h41);
        bus_write(TXA + 32'd4, 32'h42);
        bus_read(TXA, 32'h0);
        bus_read(32'h40000000, 32'h0);
        start_q.delete();
        for (int i = 1; i <= 5; i++) begin
            tx_q.push_back(8'(i));
            bus_write(TXA, 32'(i));
        end
        bus_read(CONA, 32'h03);
        cycles(205);
        bus_read(CONA, 32'h0C);
        chk("burst_frames", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < start_q.size(); i++) begin
            chk("burst_gap", 32'(start_q[i] - start_q[i-1]), 32'd40);
        end
        chk("burst_drained", 32'(tx_q.size()), 32'd0);

        // Overflow while mid-frame with a full FIFO
        bus_write(CONA, 32'h08);
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back(8'h11 + 8'(i));
            bus_write(TXA, 32'h11 + 32'(i));
        end
        bus_write(TXA, 32'hFF);
        bus_read(CONA, 32'h23);
        bus_write(CONA, 32'h20);
        bus_read(CONA, 32'h03);
        cycles(205);
        bus_read(CONA, 32'h0C);
        chk("ovf_drained", 32'(tx_q.size()), 32'd0);

        // Reset during data bit 3 of 8'h52 with 8'h77 still queued
        bus_write(CONA, 32'h08);
        start_q.delete();
        bus_write(TXA, 32'h52);
        bus_write(TXA, 32'h77);
        repeat (16) @(posedge clk);
        #1;
        chk("line_bit3", {31'd0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_mid_line", {31'd0, uart_tx}, 32'd1);
        cycles(2);
        reset = 1'b1;
        cycles(60);
        bus_read(CONA, 32'h4);
        chk("frames_after_reset", 32'(start_q.size()), 32'd1);
        chk("reads_consumed", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
